rd_tag_manager: RTL

- Read-request tag allocator between the AFU manager's read-request/response interface and the CCI-P channel-0 header generator.
- Assigns a unique mdata tag to each outgoing line read and records the requesting AFU index per tag.
- Routes returning read responses back to their AFU by tag and caps the number of reads in flight.
- Supports a drain mode so software can quiesce reads before an AFU reset.

---
 rtl/rd_tag_manager.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/rd_tag_manager.sv
// Read-request tag allocator: hands out mdata tags, remembers the requesting AFU per tag,
// routes read responses back by tag and supports draining. Optional counters: RD_TAG_STATS_EN.
module rd_tag_manager #(
    parameter int TAG_BITS    = 6,
    parameter int ADDR_WIDTH  = 48,
    parameter int AFU_ID_BITS = 4,
    parameter int DATA_WIDTH  = 512,
    parameter int MDATA_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_req_valid,
    output logic                   in_req_ready,
    input  logic [ADDR_WIDTH-1:0]  in_req_addr,
    input  logic [AFU_ID_BITS-1:0] in_req_afu_id,
    input  logic                   tx_alm_full,
    output logic                   out_req_en,
    output logic [ADDR_WIDTH-1:0]  out_req_addr,
    output logic [MDATA_WIDTH-1:0] out_req_mdata,
    input  logic                   rsp_valid,
    input  logic [MDATA_WIDTH-1:0] rsp_mdata,
    input  logic [DATA_WIDTH-1:0]  rsp_data,
    output logic                   out_rsp_valid,
    output logic [AFU_ID_BITS-1:0] out_rsp_afu_id,
    output logic [DATA_WIDTH-1:0]  out_rsp_data,
    input  logic                   drain_req,
    output logic                   drained,
    output logic [TAG_BITS:0]      outstanding,
    output logic                   err_bad_tag,
    output logic [63:0]            stat_req_cnt,
    output logic [63:0]            stat_stall_cnt
);

    localparam int NUM_TAGS = 2 ** TAG_BITS;

    typedef enum logic {
        ST_ACTIVE,
        ST_DRAINING
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_TAGS-1:0]    free_q, free_d;
    logic [TAG_BITS:0]      outstanding_q, outstanding_d;
    logic                   err_q, err_d;
    logic                   req_en_q, req_en_d;
    logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
    logic [MDATA_WIDTH-1:0] req_mdata_q, req_mdata_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic [AFU_ID_BITS-1:0] rsp_afu_q;

    logic [AFU_ID_BITS-1:0] tag_table [NUM_TAGS];

    logic [TAG_BITS-1:0]    alloc_tag;
    logic [TAG_BITS-1:0]    rsp_tag;
    logic                   accept;
    logic                   rsp_hit;
    logic                   unused_ok;

    // Upper mdata bits are ignored by design.
    assign unused_ok = &{1'b0, rsp_mdata};

    // Lowest-index free tag wins; encoder sees the pre-edge bitmap only.
    always_comb begin
        alloc_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                alloc_tag = TAG_BITS'(i);
            end
        end
    end

    assign in_req_ready = (state_q == ST_ACTIVE) && !tx_alm_full && (|free_q) && !reset;
    assign accept       = in_req_valid && in_req_ready;
    assign rsp_tag      = rsp_mdata[TAG_BITS-1:0];
    assign rsp_hit      = rsp_valid && !free_q[rsp_tag];

    always_comb begin
        free_d        = free_q;
        outstanding_d = outstanding_q + {{TAG_BITS{1'b0}}, accept} - {{TAG_BITS{1'b0}}, rsp_hit};
        err_d         = err_q || (rsp_valid && !rsp_hit);
        req_en_d      = accept;
        req_addr_d    = req_addr_q;
        req_mdata_d   = req_mdata_q;
        rsp_valid_d   = rsp_hit;
        rsp_data_d    = rsp_data_q;
        if (accept) begin
            free_d[alloc_tag] = 1'b0;
            req_addr_d        = in_req_addr;
            req_mdata_d       = MDATA_WIDTH'(alloc_tag);
        end
        if (rsp_hit) begin
            free_d[rsp_tag] = 1'b1;
            rsp_data_d      = rsp_data;
        end
    end

    always_comb begin
        state_d = state_q;
        drained = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                if (drain_req) begin
                    state_d = ST_DRAINING;
                end
            end
            ST_DRAINING: begin
                if (outstanding_q == '0) begin
                    drained = 1'b1;
                    state_d = ST_ACTIVE;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_ACTIVE;
            free_q        <= '1;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            req_en_q      <= 1'b0;
            req_addr_q    <= '0;
            req_mdata_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            free_q        <= free_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            req_en_q      <= req_en_d;
            req_addr_q    <= req_addr_d;
            req_mdata_q   <= req_mdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
        end
    end

    // Tag table as block RAM: write on allocate, registered read on response.
    // Read and write tags never collide (one is free, the other in use).
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_table[alloc_tag] <= in_req_afu_id;
        end
        if (reset) begin
            rsp_afu_q <= '0;
        end else if (rsp_hit) begin
            rsp_afu_q <= tag_table[rsp_tag];
        end
    end

    assign out_req_en     = req_en_q;
    assign out_req_addr   = req_addr_q;
    assign out_req_mdata  = req_mdata_q;
    assign out_rsp_valid  = rsp_valid_q;
    assign out_rsp_afu_id = rsp_afu_q;
    assign out_rsp_data   = rsp_data_q;
    assign outstanding    = outstanding_q;
    assign err_bad_tag    = err_q;

`ifdef RD_TAG_STATS_EN
    logic [63:0] stat_req_q, stat_req_d;
    logic [63:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_req_d   = stat_req_q + {63'd0, accept};
        stat_stall_d = stat_stall_q + {63'd0, (in_req_valid && !in_req_ready)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_req_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_req_q   <= stat_req_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_req_cnt   = stat_req_q;
    assign stat_stall_cnt = stat_stall_q;
`else
    assign stat_req_cnt   = 64'd0;
    assign stat_stall_cnt = 64'd0;
`endif

endmodule
